irq_src_cond: RTL and testbench
===============================

// Module: irq_src_cond
// PURPOSE
// Interrupt source conditioner, directly upstream of the interrupt controller.
// Synchronises raw peripheral/pin IRQ lines, optionally glitch-filters them, applies per-line polarity
// and level/edge mode, and drives registered request lines to the controller's i_src_irq.
// Edge-mode requests are latched and held until software write-1-to-clears them. Level-mode lines follow the conditioned input.
// PARAMETERS
// N_SRC        8   number of IRQ lines (1..16)
// SYNC_STAGES  2   synchroniser flops per line (>=2)
// FILT_CNT     4   consecutive differing samples needed before the filtered value changes (>=2)
// PORTS
// i_clk       in   1      system clock
// i_rst       in   1      asynchronous, active-high reset
// i_sel       in   1      MMIO block select
// i_we        in   1      MMIO write enable
// i_re        in   1      MMIO read enable
// i_addr      in   3      MMIO register index
// i_wdata     in   16     MMIO write data
// o_rdata     out  16     MMIO read data, registered
// o_rdy       out  1      MMIO ready (= i_sel)
// i_raw_irq   in   N_SRC  raw asynchronous IRQ inputs
// o_src_irq   out  N_SRC  conditioned requests, registered, to the controller's i_src_irq
// BEHAVIOUR
// - Reset (async, i_rst=1): all flops 0. o_src_irq=0, o_rdata=0. MODE, POL, FILT_EN, latches, filter counters all cleared.
// - Registers (i_addr): 0 STATUS, 1 MODE (1=edge, 0=level), 2 POL (1=active-low/falling), 3 FILT_EN.
//   - Bits [N_SRC-1:0] are used. Upper bits read 0.
//   - Writes to addr 4..7 are ignored. Reads of addr 4..7 return 0.
// - Write path: i_sel&i_we.
//   - MODE, POL and FILT_EN load i_wdata[N_SRC-1:0] on the next edge.
//   - STATUS write is W1C on the edge latches only. Level lines are unaffected.
// - Read path: i_sel&i_re.
//   - o_rdata <= selected register on the next edge (1-cycle latency). STATUS reads as o_src_irq.
//   - When i_sel&i_re is not asserted, o_rdata <= 0.
// - Per-line pipeline:
//   - sync: SYNC_STAGES-flop chain on i_raw_irq.
//   - filt:
//     - If FILT_EN=0: filt = sync output, combinationally.
//     - If FILT_EN=1: filt is a flop with a counter of clog2(FILT_CNT) bits. Counter resets to 0 whenever sync==filt and increments when they differ.
//     - On the FILT_CNT-th consecutive differing cycle: filt <= sync and counter <= 0.
//     - Clearing FILT_EN resets that line's counter and sets filt <= sync.
//   - act = filt ^ POL. prev_act flop holds the prior cycle's act. rise = act & ~prev_act.
//   - Level mode: o_src_irq <= act; latch forced 0.
//   - Edge mode: latch <= (latch & ~w1c) | rise; o_src_irq <= latch next value.
// - Latency from pin change (first sampling edge) to o_src_irq: SYNC_STAGES+1 cycles with filter off; SYNC_STAGES+FILT_CNT+1 with filter on.
// - Boundary / simultaneous cases:
//   - Rise and W1C in the same cycle: set wins, latch stays 1.
//   - A second rise while the latch is already set: absorbed. No counting.
//   - Writing MODE 1->0 clears that line's latch. Writing 0->1 starts with latch=0; a rise is required to set it.
//   - A POL write that toggles act 0->1 is a genuine rise (edge) or assertion (level). Software masks the line first.
//   - A glitch shorter than FILT_CNT cycles with filter on: no o_src_irq change, counter returns to 0.
//   - Reset mid-operation: immediate async clear of all state. The pipeline refills from the raw inputs after release.
// TESTING
// - Level, filter off, POL=0: raise raw[3] -> o_src_irq[3]=1 exactly 3 cycles later. Drop raw[3] -> 0 three cycles later.
// - Edge mode on line 0, 1-cycle raw pulse: o_src_irq[0]=1 and held. STATUS read returns 0x0001 next cycle. Write STATUS=0x0001 -> 0.
// - Simultaneous rise on line 1 and W1C 0x0002 in the same cycle -> o_src_irq[1] stays 1.
// - FILT_EN[2]=1: 3-cycle glitch -> no output. 6-cycle pulse -> o_src_irq[2]=1 at cycle 2+4+1=7 after the rise.
// - POL[5]=1 with raw[5]=0, level mode -> o_src_irq[5]=1 one cycle after the write. Raise raw[5] -> 0 after 3 cycles.
// - Assert i_rst asynchronously mid-edge-latch -> o_src_irq=0 and MODE=0 immediately; read of addr 6 returns 0x0000.

Source files
------------

// File: rtl/irq_src_cond.sv
`default_nettype none
// ============================================================================
// Module   : irq_src_cond
// Purpose  : Interrupt source conditioner. Synchronises raw IRQ lines, applies
//            an optional per-line glitch filter, per-line polarity and
//            level/edge mode, and drives registered request lines to the
//            interrupt controller. Edge requests are latched until software
//            clears them by writing 1 to STATUS.
// Ports    : i_clk      system clock
//            i_rst      asynchronous active-high reset
//            i_sel      MMIO block select
//            i_we       MMIO write enable
//            i_re       MMIO read enable
//            i_addr     MMIO register index (0 STATUS, 1 MODE, 2 POL, 3 FILT_EN)
//            i_wdata    MMIO write data
//            o_rdata    MMIO read data, registered, 1-cycle latency
//            o_rdy      MMIO ready, equal to i_sel
//            i_raw_irq  raw asynchronous IRQ inputs
//            o_src_irq  conditioned, registered requests
// Revision : 1.0  initial release
// ============================================================================
module irq_src_cond #(
  parameter int N_SRC       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CNT    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_sel,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [2:0]       i_addr,
  input  logic [15:0]      i_wdata,
  output logic [15:0]      o_rdata,
  output logic             o_rdy,
  input  logic [N_SRC-1:0] i_raw_irq,
  output logic [N_SRC-1:0] o_src_irq
);

  localparam int         CNT_W         = (FILT_CNT > 1) ? $clog2(FILT_CNT) : 1;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(FILT_CNT - 1);
  localparam logic [2:0] c_ADDR_STATUS = 3'd0;
  localparam logic [2:0] c_ADDR_MODE   = 3'd1;
  localparam logic [2:0] c_ADDR_POL    = 3'd2;
  localparam logic [2:0] c_ADDR_FILT   = 3'd3;

  logic [N_SRC-1:0] r_sync [SYNC_STAGES];
  logic [N_SRC-1:0] r_mode;
  logic [N_SRC-1:0] r_pol;
  logic [N_SRC-1:0] r_filt_en;
  logic [N_SRC-1:0] r_prev_act;
  logic [N_SRC-1:0] r_latch;

  logic [N_SRC-1:0] w_sync;
  logic [N_SRC-1:0] w_filt;
  logic [N_SRC-1:0] w_act;
  logic [N_SRC-1:0] w_rise;
  logic [N_SRC-1:0] w_w1c;
  logic [N_SRC-1:0] w_latch_nxt;
  logic [N_SRC-1:0] w_irq_nxt;
  logic             w_wr;
  logic             w_rd;
  logic [15:0]      w_rd_mux;

  assign w_wr  = i_sel & i_we;
  assign w_rd  = i_sel & i_re;
  assign o_rdy = i_sel;

  // Upper write-data bits have no backing register when N_SRC < 16.
  if (N_SRC < 16) begin : g_wdata_pad
    logic w_unused_wdata;
    assign w_unused_wdata = ^i_wdata[15:N_SRC];
  end

  // --------------------------------------------------------------------------
  // Synchroniser chain
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= i_raw_irq;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Per-line glitch filter. While disabled the flop shadows the synchroniser
  // so that enabling the filter never produces a spurious transition.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_line
    logic             r_filt;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_filt <= 1'b0;
        r_cnt  <= '0;
      end else if (!r_filt_en[gi]) begin
        r_filt <= w_sync[gi];
        r_cnt  <= '0;
      end else if (w_sync[gi] == r_filt) begin
        r_cnt  <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_filt <= w_sync[gi];
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end

    assign w_filt[gi] = r_filt_en[gi] ? r_filt : w_sync[gi];
  end

  // --------------------------------------------------------------------------
  // Polarity, edge detection and request generation
  // --------------------------------------------------------------------------
  assign w_act  = w_filt ^ r_pol;
  assign w_rise = w_act & ~r_prev_act;
  assign w_w1c  = (w_wr && (i_addr == c_ADDR_STATUS)) ? i_wdata[N_SRC-1:0] : '0;

  // Set dominates clear; level-mode lines keep their latch at 0 so a later
  // switch to edge mode needs a fresh rise.
  assign w_latch_nxt = r_mode & ((r_latch & ~w_w1c) | w_rise);
  assign w_irq_nxt   = w_latch_nxt | (~r_mode & w_act);

  always_comb begin
    w_rd_mux = '0;
    case (i_addr)
      c_ADDR_STATUS: w_rd_mux[N_SRC-1:0] = o_src_irq;
      c_ADDR_MODE:   w_rd_mux[N_SRC-1:0] = r_mode;
      c_ADDR_POL:    w_rd_mux[N_SRC-1:0] = r_pol;
      c_ADDR_FILT:   w_rd_mux[N_SRC-1:0] = r_filt_en;
      default:       w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode     <= '0;
      r_pol      <= '0;
      r_filt_en  <= '0;
      r_prev_act <= '0;
      r_latch    <= '0;
      o_src_irq  <= '0;
      o_rdata    <= '0;
    end else begin
      if (w_wr && (i_addr == c_ADDR_MODE)) begin
        r_mode <= i_wdata[N_SRC-1:0];
      end
      if (w_wr && (i_addr == c_ADDR_POL)) begin
        r_pol <= i_wdata[N_SRC-1:0];
      end
      if (w_wr && (i_addr == c_ADDR_FILT)) begin
        r_filt_en <= i_wdata[N_SRC-1:0];
      end
      r_prev_act <= w_act;
      r_latch    <= w_latch_nxt;
      o_src_irq  <= w_irq_nxt;
      o_rdata    <= w_rd ? w_rd_mux : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_src_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_src_cond
// Purpose  : Self-checking bench for irq_src_cond. A behavioural model queues
//            the expected request lines and read data per clock; a monitor
//            pops and compares. Directed sequences cover the documented
//            corner cases, followed by a randomized run.
// Revision : 1.0  initial release
// ============================================================================
module tb_irq_src_cond;

  localparam int N  = 8;
  localparam int SS = 2;
  localparam int FC = 4;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          sel   = 1'b0;
  logic          we    = 1'b0;
  logic          re    = 1'b0;
  logic [2:0]    addr  = 3'd0;
  logic [15:0]   wdata = 16'h0;
  logic [15:0]   rdata;
  logic          rdy;
  logic [N-1:0]  raw   = '0;
  logic [N-1:0]  irq;

  int checks = 0;
  int errors = 0;

  irq_src_cond #(
    .N_SRC       (N),
    .SYNC_STAGES (SS),
    .FILT_CNT    (FC)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_sel     (sel),
    .i_we      (we),
    .i_re      (re),
    .i_addr    (addr),
    .i_wdata   (wdata),
    .o_rdata   (rdata),
    .o_rdy     (rdy),
    .i_raw_irq (raw),
    .o_src_irq (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: raw history queue stands in for the synchroniser, the
  // filter is tracked as a run length of disagreeing samples.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [N-1:0] irq;
    logic [15:0]  rd;
  } exp_t;

  exp_t         exp_q[$];
  logic [N-1:0] raw_hist[$];
  logic [N-1:0] m_mode, m_pol, m_fen, m_filt, m_prev, m_latch, m_out;
  int           m_run[N];

  task automatic model_reset();
    raw_hist.delete();
    m_mode = '0; m_pol = '0; m_fen = '0; m_filt = '0;
    m_prev = '0; m_latch = '0; m_out = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] sync_now, filt_eff, act, rise, w1c, latch_n, out_n;
    logic [15:0]  rd_n;
    logic         wr, rd;
    exp_t         e;
    wr = sel & we;
    rd = sel & re;
    sync_now = (raw_hist.size() >= SS) ? raw_hist[raw_hist.size() - SS] : '0;
    for (int i = 0; i < N; i++) filt_eff[i] = m_fen[i] ? m_filt[i] : sync_now[i];
    act  = filt_eff ^ m_pol;
    rise = act & ~m_prev;
    w1c  = (wr && addr == 3'd0) ? wdata[N-1:0] : '0;
    for (int i = 0; i < N; i++) begin
      if (m_mode[i]) begin
        latch_n[i] = (m_latch[i] && !w1c[i]) || rise[i];
        out_n[i]   = latch_n[i];
      end else begin
        latch_n[i] = 1'b0;
        out_n[i]   = act[i];
      end
    end
    rd_n = 16'h0;
    if (rd) begin
      case (addr)
        3'd0:    rd_n = 16'(m_out);
        3'd1:    rd_n = 16'(m_mode);
        3'd2:    rd_n = 16'(m_pol);
        3'd3:    rd_n = 16'(m_fen);
        default: rd_n = 16'h0;
      endcase
    end
    for (int i = 0; i < N; i++) begin
      if (!m_fen[i]) begin
        m_filt[i] = sync_now[i];
        m_run[i]  = 0;
      end else if (sync_now[i] != m_filt[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == FC) begin
          m_filt[i] = sync_now[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_prev  = act;
    m_latch = latch_n;
    m_out   = out_n;
    if (wr && addr == 3'd1) m_mode = wdata[N-1:0];
    if (wr && addr == 3'd2) m_pol  = wdata[N-1:0];
    if (wr && addr == 3'd3) m_fen  = wdata[N-1:0];
    raw_hist.push_back(raw);
    if (raw_hist.size() > SS) void'(raw_hist.pop_front());
    e.irq = out_n;
    e.rd  = rd_n;
    exp_q.push_back(e);
  endtask

  initial begin : model
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
        exp_q.delete();
      end else begin
        model_step();
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: no expectation queued at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("src_irq", 16'(irq), 16'(e.irq));
          check("rdata", rdata, e.rd);
        end
        check("rdy", 16'(rdy), 16'(sel));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers, all entered and left on a falling clock edge
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mmio_write(input logic [2:0] a, input logic [15:0] d);
    sel = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic mmio_read(input logic [2:0] a, output logic [15:0] d);
    sel = 1'b1; re = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    d = rdata;
    sel = 1'b0; re = 1'b0;
  endtask

  initial begin : stim
    logic [15:0] d;
    tick(3);
    check("reset_irq", 16'(irq), 16'h0);
    check("reset_rdata", rdata, 16'h0);
    rst = 1'b0;
    tick(2);

    // Level mode, filter off: 3-cycle latency both ways.
    raw[3] = 1'b1;
    tick(2); check("lvl_rise_early", 16'(irq[3]), 16'h0);
    tick(1); check("lvl_rise", 16'(irq[3]), 16'h1);
    raw[3] = 1'b0;
    tick(2); check("lvl_fall_early", 16'(irq[3]), 16'h1);
    tick(1); check("lvl_fall", 16'(irq[3]), 16'h0);

    // Edge mode, single-cycle pulse is latched, read back, then cleared.
    mmio_write(3'd1, 16'h0001);
    raw[0] = 1'b1; tick(1); raw[0] = 1'b0;
    tick(2); check("edge_set", 16'(irq[0]), 16'h1);
    tick(4); check("edge_hold", 16'(irq[0]), 16'h1);
    mmio_read(3'd0, d); check("status_read", d, 16'h0001);
    mmio_write(3'd0, 16'h0001); check("w1c_clear", 16'(irq[0]), 16'h0);

    // Rise and W1C in the same cycle: set wins.
    mmio_write(3'd1, 16'h0003);
    raw[1] = 1'b1; tick(1); raw[1] = 1'b0; tick(1);
    mmio_write(3'd0, 16'h0002); check("set_wins", 16'(irq[1]), 16'h1);
    tick(2); check("set_wins_hold", 16'(irq[1]), 16'h1);
    mmio_write(3'd0, 16'h0002); check("w1c_line1", 16'(irq[1]), 16'h0);

    // MODE 1->0 drops the latch; 0->1 starts with the latch clear.
    raw[0] = 1'b1; tick(1); raw[0] = 1'b0;
    tick(2); check("edge_set2", 16'(irq[0]), 16'h1);
    mmio_write(3'd1, 16'h0000); check("mode_off_edge", 16'(irq[0]), 16'h1);
    tick(1); check("mode_off_clear", 16'(irq[0]), 16'h0);
    mmio_write(3'd1, 16'h0001);
    tick(2); check("mode_on_noset", 16'(irq[0]), 16'h0);
    mmio_write(3'd1, 16'h0000);

    // Glitch filter on line 2.
    mmio_write(3'd3, 16'h0004);
    raw[2] = 1'b1; tick(3); raw[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1); check("glitch_blocked", 16'(irq[2]), 16'h0);
    end
    raw[2] = 1'b1;
    tick(6); check("filt_early", 16'(irq[2]), 16'h0);
    raw[2] = 1'b0;
    tick(1); check("filt_rise", 16'(irq[2]), 16'h1);
    tick(5); check("filt_fall_early", 16'(irq[2]), 16'h1);
    tick(1); check("filt_fall", 16'(irq[2]), 16'h0);
    mmio_write(3'd3, 16'h0000);

    // Polarity inversion in level mode.
    mmio_write(3'd2, 16'h0020); check("pol_early", 16'(irq[5]), 16'h0);
    tick(1); check("pol_assert", 16'(irq[5]), 16'h1);
    raw[5] = 1'b1;
    tick(2); check("pol_raw_early", 16'(irq[5]), 16'h1);
    tick(1); check("pol_raw_deassert", 16'(irq[5]), 16'h0);
    raw[5] = 1'b0;
    mmio_write(3'd2, 16'h0000);
    tick(5);

    // Asynchronous reset while an edge latch is set and a read is pending.
    mmio_write(3'd1, 16'h0001);
    raw[0] = 1'b1; tick(1); raw[0] = 1'b0;
    tick(2); check("pre_rst_latch", 16'(irq[0]), 16'h1);
    sel = 1'b1; re = 1'b1; addr = 3'd0;
    tick(1); check("pre_rst_rdata", rdata, 16'h0001);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_irq", 16'(irq), 16'h0);
    check("async_rst_rdata", rdata, 16'h0);
    @(negedge clk);
    sel = 1'b0; re = 1'b0;
    rst = 1'b0;
    mmio_read(3'd1, d); check("rst_mode", d, 16'h0);
    mmio_read(3'd6, d); check("addr6_read", d, 16'h0);
    raw[3] = 1'b1;
    tick(3); check("refill", 16'(irq[3]), 16'h1);
    raw[3] = 1'b0;
    tick(4);

    // Randomized traffic; the scoreboard checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      sel = 1'b0; we = 1'b0; re = 1'b0;
      if ($urandom_range(3) == 0) begin
        sel   = ($urandom_range(7) != 0);
        we    = 1'($urandom_range(1));
        re    = 1'($urandom_range(1));
        addr  = 3'($urandom_range(7));
        wdata = 16'($urandom);
      end
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5) == 0) raw[i] = ~raw[i];
      end
      @(negedge clk);
    end
    sel = 1'b0; we = 1'b0; re = 1'b0;
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
